ifetch_unit: RTL and testbench

Multi-cycle instruction fetch and PC sequencing stage for the MIPS core, directly upstream of the control decoder. It owns the program counter, fetches words from instruction memory over a req/ack handshake, and holds the current instruction stable, with decoded bit-fields, for decode and execute. When execute signals completion it consumes the decoder's `PC_sel` plus the branch condition and register target, then computes and commits the next PC.

---
 rtl/ifetch_unit_pkg.sv | 22 ++
 rtl/ifetch_unit_if.sv | 10 +
 rtl/ifetch_unit_npc.sv | 33 +++
 rtl/ifetch_unit.sv | 111 +++++++++++
 tb/tb_ifetch_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC select values, FSM states
// and the default reset vector.
package ifetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam logic [1:0] PC_MUX_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_MUX_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_MUX_SEL_J   = 2'b10;
  localparam logic [1:0] PC_MUX_SEL_JR  = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface ifetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (output im_req, output im_addr, input im_ack, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);
endinterface

// File: rtl/ifetch_unit_npc.sv
// Combinational next-PC selection with misaligned-target detection.
module ifetch_unit_npc
  import ifetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [1:0]  pc_sel_i,
  input  logic        br_taken_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] imm26_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] npc_o,
  output logic        misalign_o
);

  logic [31:0] br_offset;

  assign br_offset = {{14{imm16_i[15]}}, imm16_i, 2'b00};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    npc_o = pc_plus4_i;
    case (pc_sel_i)
      PC_MUX_SEL_BR: if (br_taken_i) npc_o = pc_plus4_i + br_offset;
      PC_MUX_SEL_J:  npc_o = {pc_plus4_i[31:28], imm26_i, 2'b00};
      PC_MUX_SEL_JR: npc_o = jr_target_i;
      default:       npc_o = pc_plus4_i;
    endcase
  end

  assign misalign_o = !word_aligned(npc_o);

endmodule

// File: rtl/ifetch_unit.sv
// Fetch/PC sequencing stage: fetches one word, holds it for decode/execute,
// then commits the next PC when execute completes.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rstn,
  ifetch_unit_if.master im,
  input  logic          ex_done,
  input  logic [1:0]    PC_sel,
  input  logic          br_taken,
  input  logic [31:0]   jr_target,
  output logic [31:0]   instr,
  output logic [5:0]    opcode,
  output logic [5:0]    func,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [15:0]   imm16,
  output logic [25:0]   imm26,
  output logic          instr_valid,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic [31:0]   retired,
  output logic          fault
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] npc;
  logic        npc_misalign;

  ifetch_unit_npc u_npc (
    .pc_plus4_i  (pc_plus4),
    .pc_sel_i    (PC_sel),
    .br_taken_i  (br_taken),
    .imm16_i     (imm16),
    .imm26_i     (imm26),
    .jr_target_i (jr_target),
    .npc_o       (npc),
    .misalign_o  (npc_misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: begin
        if (im.im_ack) begin
          instr_d = im.im_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          if (npc_misalign) begin
            state_d = ST_FAULT;
          end else begin
            pc_d      = npc;
            retired_d = retired_q + 32'd1;
            state_d   = ST_FETCH;
          end
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // Reset also gates the request so memory never sees one while rstn is low.
  assign im.im_req   = rstn && (state_q == ST_FETCH);
  assign im.im_addr  = pc_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign fault       = (state_q == ST_FAULT);

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign retired  = retired_q;
  assign instr    = instr_q;
  assign opcode   = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign shamt    = instr_q[10:6];
  assign func     = instr_q[5:0];
  assign imm16    = instr_q[15:0];
  assign imm26    = instr_q[25:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by a
// randomized instruction stream compared against an arithmetic PC model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_done;
  logic [1:0]  PC_sel;
  logic        br_taken;
  logic [31:0] jr_target;
  logic [31:0] instr, pc, pc_plus4, retired;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        instr_valid, fault;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_pc, m_retired, m_instr;

  ifetch_unit_if bus ();

  ifetch_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .im          (bus.master),
    .ex_done     (ex_done),
    .PC_sel      (PC_sel),
    .br_taken    (br_taken),
    .jr_target   (jr_target),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .imm16       (imm16),
    .imm26       (imm26),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired     (retired),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                           input logic [1:0] sel, input logic br,
                                           input logic [31:0] jr);
    logic [31:0] link;
    int          off;
    link = cur_pc + 32'd4;
    off  = int'($signed(word[15:0])) * 4;
    case (sel)
      2'd1:    return br ? link + 32'(off) : link;
      2'd2:    return (link & 32'hF000_0000) | (32'(word[25:0]) * 32'd4);
      2'd3:    return jr;
      default: return link;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},     {31'd0, bus.im_req}, 32'd0);
    check({tag, "_pc"},      pc, 32'h0000_3000);
    check({tag, "_retired"}, retired, 32'd0);
    check({tag, "_fault"},   {31'd0, fault}, 32'd0);
    check({tag, "_instr"},   instr, 32'd0);
    check({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
  endtask

  // Asserts reset away from the clock edge, holds it across one edge, releases.
  task automatic pulse_reset(input string tag);
    rstn = 1'b0;
    #1;
    m_pc = 32'h0000_3000; m_retired = 32'd0; m_instr = 32'd0;
    check_reset_values(tag);
    step();
    check_reset_values({tag, "_held"});
    rstn = 1'b1;
    #1;
    check({tag, "_req_rise"}, {31'd0, bus.im_req}, 32'd1);
    check({tag, "_addr"}, bus.im_addr, 32'h0000_3000);
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    check("fetch_req", {31'd0, bus.im_req}, 32'd1);
    check("fetch_addr", bus.im_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      bus.im_ack   = 1'b0;
      bus.im_rdata = $urandom;
      ex_done      = 1'($urandom_range(0, 1));
      step();
      check("wait_req", {31'd0, bus.im_req}, 32'd1);
      check("wait_addr", bus.im_addr, m_pc);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    bus.im_ack   = 1'b1;
    bus.im_rdata = word;
    ex_done      = 1'b0;
    step();
    bus.im_ack   = 1'b0;
    bus.im_rdata = $urandom;
    m_instr = word;
    check("ack_valid", {31'd0, instr_valid}, 32'd1);
    check("ack_req", {31'd0, bus.im_req}, 32'd0);
    check("ack_instr", instr, word);
    check("ack_fields", {opcode, rs, rt, rd, shamt, func}, word);
    check("ack_imm", {imm26[25:16], imm16}, word[25:0]);
    check("ack_pc", pc, m_pc);
  endtask

  task automatic exec_idle(input int n);
    for (int i = 0; i < n; i++) begin
      ex_done      = 1'b0;
      bus.im_ack   = 1'($urandom_range(0, 1));
      bus.im_rdata = $urandom;
      step();
      check("idle_instr", instr, m_instr);
      check("idle_valid", {31'd0, instr_valid}, 32'd1);
      check("idle_req", {31'd0, bus.im_req}, 32'd0);
    end
    bus.im_ack = 1'b0;
  endtask

  task automatic execute(input logic [1:0] sel, input logic br, input logic [31:0] jr);
    logic [31:0] nxt;
    logic        exp_fault;
    nxt       = ref_next(m_pc, m_instr, sel, br, jr);
    PC_sel    = sel;
    br_taken  = br;
    jr_target = jr;
    ex_done   = 1'b1;
    step();
    ex_done   = 1'b0;
    PC_sel    = 2'($urandom);
    br_taken  = 1'($urandom);
    jr_target = $urandom;
    exp_fault = (nxt % 4) != 0;
    if (!exp_fault) begin
      m_pc      = nxt;
      m_retired = m_retired + 32'd1;
    end
    check("exe_pc", pc, m_pc);
    check("exe_pc_plus4", pc_plus4, m_pc + 32'd4);
    check("exe_retired", retired, m_retired);
    check("exe_fault", {31'd0, fault}, {31'd0, exp_fault});
    check("exe_req", {31'd0, bus.im_req}, {31'd0, !exp_fault});
    check("exe_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] word;
    logic [1:0]  sel;
    rstn = 1'b1; ex_done = 1'b0; PC_sel = 2'd0; br_taken = 1'b0; jr_target = 32'd0;
    bus.im_ack = 1'b0; bus.im_rdata = 32'd0;
    #2;
    pulse_reset("reset");

    // ori, then sequential commit.
    fetch(32'h3402_0005, 0);
    check("ori_opcode", {26'd0, opcode}, 32'h0D);
    check("ori_imm16", {16'd0, imm16}, 32'h0005);
    execute(2'b00, 1'b0, 32'd0);
    check("ori_pc", pc, 32'h0000_3004);
    check("ori_retired", retired, 32'd1);

    // beq at 0x3010, taken and not taken.
    fetch(32'h0800_0C04, 0);  execute(2'b10, 1'b0, 32'd0);
    check("j_to_3010", pc, 32'h0000_3010);
    fetch(32'h1000_FFFC, 1);  execute(2'b01, 1'b1, 32'd0);
    check("beq_taken", pc, 32'h0000_3004);
    fetch(32'h0800_0C04, 0);  execute(2'b10, 1'b0, 32'd0);
    fetch(32'h1000_FFFC, 0);  execute(2'b01, 1'b0, 32'd0);
    check("beq_not_taken", pc, 32'h0000_3014);

    // j at 0x3020, then jr.
    fetch(32'h0000_0008, 0);  execute(2'b11, 1'b0, 32'h0000_3020);
    fetch(32'h0800_0C10, 0);  execute(2'b10, 1'b0, 32'd0);
    check("j_3040", pc, 32'h0000_3040);
    fetch(32'h03E0_0008, 0);  execute(2'b11, 1'b0, 32'h0000_3008);
    check("jr_3008", pc, 32'h0000_3008);

    // Withheld ack, stray acks during EXEC.
    fetch(32'h2408_1234, 5);
    exec_idle(4);
    execute(2'b00, 1'b0, 32'd0);

    // PC wrap and jump region from the top of the address space.
    fetch(32'h03E0_0008, 0);  execute(2'b11, 1'b0, 32'hFFFF_FFFC);
    fetch(32'h0800_0001, 2);  execute(2'b10, 1'b0, 32'd0);
    check("j_top_region", pc, 32'h0000_0004);
    fetch(32'h03E0_0008, 0);  execute(2'b11, 1'b0, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0);  execute(2'b00, 1'b0, 32'd0);
    check("pc_wrap", pc, 32'd0);

    // Reset mid-FETCH and mid-EXEC.
    bus.im_ack = 1'b0;
    step();
    pulse_reset("rst_fetch");
    fetch(32'h3402_0005, 0);
    exec_idle(1);
    pulse_reset("rst_exec");

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      word = $urandom;
      fetch(word, $urandom_range(0, 3));
      exec_idle($urandom_range(0, 2));
      sel = 2'($urandom);
      execute(sel, 1'($urandom), $urandom & 32'hFFFF_FFFC);
    end

    // Misaligned jr: sticky fault, nothing committed, request stays low.
    fetch(32'h03E0_0008, 0);
    word = pc;
    execute(2'b11, 1'b0, 32'h0000_3006);
    check("fault_set", {31'd0, fault}, 32'd1);
    check("fault_pc", pc, word);
    for (int i = 0; i < 6; i++) begin
      bus.im_ack   = 1'($urandom_range(0, 1));
      ex_done      = 1'($urandom_range(0, 1));
      PC_sel       = 2'($urandom);
      jr_target    = $urandom & 32'hFFFF_FFFC;
      step();
      check("fault_hold", {31'd0, fault}, 32'd1);
      check("fault_req", {31'd0, bus.im_req}, 32'd0);
      check("fault_valid", {31'd0, instr_valid}, 32'd0);
      check("fault_pc_hold", pc, word);
      check("fault_retired", retired, m_retired);
    end
    bus.im_ack = 1'b0;
    ex_done    = 1'b0;
    pulse_reset("rst_fault");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
